// File: rtl/jtlt_sched_pkg.sv
// Shared definitions for the JTL link scheduler: default sizing, FSM state
// encoding and width helpers used by the interface, arbiter and top.
package jtlt_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int TMO_DEF   = 15;
  localparam int GAP_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ARR = 2'd2,
    RECOVER  = 2'd3
  } state_t;

  // Requester index width; a single requester still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width large enough to hold max(tmo, gap).
  function automatic int cnt_w(input int tmo, input int gap);
    int m;
    m = (tmo > gap) ? tmo : gap;
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/jtlt_link_scheduler_if.sv
// Requester handshake plus JTL toggle lines shared by the scheduler and its
// environment. The scheduler uses the slave modport.
interface jtlt_link_scheduler_if
  import jtlt_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) ();

  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] ack;
  logic             jtl_in;
  logic             jtl_out;
  logic [IW-1:0]    src;
  logic             busy;
  logic             err_tmo;
  logic             err_stray;

  modport slave (
    input  req, jtl_out,
    output ack, jtl_in, src, busy, err_tmo, err_stray
  );

  modport master (
    output req, jtl_out,
    input  ack, jtl_in, src, busy, err_tmo, err_stray
  );

endinterface

// File: rtl/jtlt_rr_arbiter.sv
// Combinational round-robin selector: scans requesters starting at i_ptr
// and returns the first pending one as a one-hot grant and an index.
module jtlt_rr_arbiter
  import jtlt_sched_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx
);

  logic [IW:0]      w_sum  [N_REQ];
  logic [IW-1:0]    w_cand [N_REQ];
  logic [N_REQ-1:0] w_hit;
  logic             w_any;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      // Candidate at rotation offset gi, wrapped modulo N_REQ
      assign w_sum[gi]  = {1'b0, i_ptr} + (IW+1)'(gi);
      assign w_cand[gi] = (w_sum[gi] >= (IW+1)'(N_REQ)) ?
                          IW'(w_sum[gi] - (IW+1)'(N_REQ)) : IW'(w_sum[gi]);
      assign w_hit[gi]  = i_req[w_cand[gi]];
      assign o_grant[gi] = w_any && (o_idx == IW'(gi));
    end
  endgenerate

  // Smallest offset from the pointer with a pending request wins
  always_comb begin
    w_any = 1'b0;
    o_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_any = 1'b1;
        o_idx = w_cand[k];
      end
    end
  end

endmodule

// File: rtl/jtlt_link_scheduler.sv
// Schedules single-pulse transfers of N_REQ requesters over one JTL.
// A launch toggles jtl_in; the matching toggle on jtl_out completes the
// request, otherwise a timeout retries the same requester. A recovery
// window of GAP+1 cycles follows every launch outcome.
module jtlt_link_scheduler
  import jtlt_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int TMO   = TMO_DEF,
  parameter int GAP   = GAP_DEF
) (
  input logic                   clk,
  input logic                   rst,
  jtlt_link_scheduler_if.slave  bus
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = cnt_w(TMO, GAP);
  localparam logic [CW-1:0] TMO_LAST = CW'((TMO > 0) ? TMO - 1 : 0);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP);

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_src;
  logic [N_REQ-1:0] r_ack;
  logic             r_jtl_in;
  logic             r_ref;
  logic             r_busy;
  logic             r_err_tmo;
  logic             r_err_stray;
  logic [CW-1:0]    r_tmo;
  logic [CW-1:0]    r_gap;

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_idx;
  logic [N_REQ-1:0] w_src_hot;
  logic [IW-1:0]    w_ptr_next;
  logic             w_flip;

  jtlt_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_hot
      assign w_src_hot[gi] = (r_src == IW'(gi));
    end
  endgenerate

  assign w_flip     = (bus.jtl_out != r_ref);
  assign w_ptr_next = (r_src == IW'(N_REQ - 1)) ? '0 : r_src + 1'b1;

  // Link FSM with registered outputs; a jtl_out flip outside WAIT_ARR is stray
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_src       <= '0;
      r_ack       <= '0;
      r_jtl_in    <= 1'b0;
      r_ref       <= 1'b0;
      r_busy      <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_err_stray <= 1'b0;
      r_tmo       <= '0;
      r_gap       <= '0;
    end else begin
      r_ack       <= '0;
      r_err_tmo   <= 1'b0;
      r_err_stray <= 1'b0;
      if (w_flip) begin
        r_ref <= bus.jtl_out;
        if (r_state != WAIT_ARR) r_err_stray <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_src   <= w_idx;
            r_busy  <= 1'b1;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_jtl_in <= ~r_jtl_in;
          r_tmo    <= '0;
          r_state  <= WAIT_ARR;
        end
        WAIT_ARR: begin
          // Arrival takes priority over a timeout in the same cycle
          if (w_flip) begin
            r_ack   <= w_src_hot;
            r_ptr   <= w_ptr_next;
            r_gap   <= GAP_LD;
            r_state <= RECOVER;
          end else if (r_tmo >= TMO_LAST) begin
            r_err_tmo <= 1'b1;
            r_gap     <= GAP_LD;
            r_state   <= RECOVER;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        RECOVER: begin
          if (r_gap == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.jtl_in    = r_jtl_in;
  assign bus.src       = r_src;
  assign bus.busy      = r_busy;
  assign bus.err_tmo   = r_err_tmo;
  assign bus.err_stray = r_err_stray;

endmodule

// File: doc/jtlt_link_scheduler.md
JTLT_LINK_SCHEDULER -- requirements
Module: jtlt_link_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one JTL link.
REQ-002 SHALL have parameter TMO, default 15, the cycle count to wait for pulse arrival before declaring a timeout.
REQ-003 SHALL have parameter GAP, default 3, the JTL recovery cycles required between pulses.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-006 SHALL have port req, input, N_REQ bits, level request per requester, held until its ack.
REQ-007 SHALL have port ack, output, N_REQ bits, a one-cycle one-hot pulse that completes a request.
REQ-008 SHALL have port jtl_in, output, 1 bit, a toggle line to the JTL input where each level flip is one SFQ pulse.
REQ-009 SHALL have port jtl_out, input, 1 bit, a toggle line from the JTL output where each flip is one arrived pulse.
REQ-010 SHALL have port src, output, clog2(N_REQ) bits, the index of the requester currently owning the link.
REQ-011 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-012 SHALL have port err_tmo, output, 1 bit, a one-cycle pulse on arrival timeout.
REQ-013 SHALL have port err_stray, output, 1 bit, a one-cycle pulse on a jtl_out flip when no pulse is in flight.

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, WAIT_ARR and RECOVER.
REQ-015 In IDLE with any req bit set, SHALL grant round-robin starting at pointer ptr, latch src, and go to LAUNCH.
REQ-016 In IDLE with no req bit set, SHALL hold all outputs stable.
REQ-017 In LAUNCH, SHALL flip jtl_in exactly once, clear the timeout counter, and go to WAIT_ARR next cycle.
REQ-018 SHALL detect arrival as jtl_out != ref, where ref is a registered copy updated to jtl_out on every detected flip.
REQ-019 In WAIT_ARR on arrival, SHALL pulse ack[src] for 1 cycle, set ptr=(src+1) mod N_REQ, load the gap counter with GAP, and go to RECOVER.
REQ-020 In WAIT_ARR with no arrival after TMO cycles, SHALL pulse err_tmo, issue no ack, leave ptr unchanged so the same requester retries, and go to RECOVER.
REQ-021 If arrival and timeout occur in the same cycle, SHALL treat the event as arrival.
REQ-022 In RECOVER, SHALL decrement the gap counter and return to IDLE when it reaches 0; with GAP=0, SHALL return to IDLE the next cycle.
REQ-023 SHALL keep the minimum spacing between jtl_in flips at 3+GAP cycles, including back-to-back requests.
REQ-024 SHALL pulse err_stray and update ref on any jtl_out flip seen in IDLE, LAUNCH or RECOVER, with no state change.
REQ-025 SHALL ignore a req bit that drops before its ack; the current transaction completes and ack is still pulsed.
REQ-026 SHALL make the round-robin pointer wrap from N_REQ-1 to 0.
REQ-027 SHALL size all counters to hold max(TMO,GAP) without overflow.

Reset
REQ-028 Asserting rst at any time, including mid-transaction, SHALL immediately set state=IDLE, ptr=0, src=0, ack=0, jtl_in=0, ref=0, busy=0, err_tmo=0, err_stray=0 and both counters to 0.
REQ-029 After reset, SHALL report a jtl_out level of 1 at the first post-reset sample as err_stray once.

Structure
REQ-030 SHALL define the state enum and default N_REQ, TMO and GAP in shared package jtlt_sched_pkg.
REQ-031 SHALL implement round-robin selection in one sub-module, jtlt_rr_arbiter, which is combinational: req and ptr in, one-hot grant and index out.

Verification
REQ-032 With GAP=3 and TMO=15, a bench SHALL drive req=0001 with a loopback delay of 2 cycles and check 1 jtl_in flip, ack=0001 two cycles after LAUNCH, busy low again 4 cycles after ack, and ptr=1.
REQ-033 A bench SHALL hold req=1111 continuously and check ack order 0001, 0010, 0100, 1000, 0001 with jtl_in flips at least 6 cycles apart.
REQ-034 A bench SHALL drive req=0100 with no loopback and check err_tmo at cycle 15 of WAIT_ARR, no ack, then a retry flip to src=2 after RECOVER.
REQ-035 A bench SHALL flip jtl_out while in IDLE and check a single err_stray pulse with no state change.
REQ-036 A bench SHALL assert rst during WAIT_ARR and check all outputs at reset values in the same cycle, then a request afterwards served from ptr=0.
REQ-037 A bench SHALL apply arrival on exactly timeout cycle 15 and check ack asserted and err_tmo low.
